// File: rtl/lcd_host.sv
// Purpose: host side of the LCD image controller; serves the source image as a ROM,
//          sequences queued opcodes onto cmd/cmd_valid/busy, captures image-RAM writes.
// Latency: cmd/cmd_valid registered (opcode visible one cycle after the ISSUE decision);
//          captured pixels visible in res_q/checksum/wr_count right after the capturing edge.
// Backpressure: opcodes wait in WAIT while busy=1; queue pushes are dropped when full
//          or outside IDLE; a watchdog ends a stalled sequence with err_timeout.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   img_we/img_addr/img_din   source image load (IDLE only)
//   cmd_we/cmd_din        command queue push (IDLE only, dropped when full)
//   start                 leaves IDLE and begins the sequence
//   irom_rd/irom_a/irom_q controller image-ROM read port (combinational)
//   cmd/cmd_valid/busy    opcode handshake to the controller
//   iram_valid/iram_a/iram_d  controller image-RAM writes, captured into res
//   done                  controller finished
//   res_addr/res_q        result readback (combinational)
//   checksum/wr_count     running sum and count of captured writes
//   host_done/err_timeout/err_count/auto_wr   status flags
module lcd_host #(
    parameter int         CMD_DEPTH = 16,
    parameter logic [3:0] NOOP_CMD  = 4'hF,
    parameter int         TIMEOUT   = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        img_we,
    input  logic [5:0]  img_addr,
    input  logic [7:0]  img_din,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_din,
    input  logic        start,
    input  logic        irom_rd,
    input  logic [5:0]  irom_a,
    output logic [7:0]  irom_q,
    output logic [3:0]  cmd,
    output logic        cmd_valid,
    input  logic        busy,
    input  logic        iram_valid,
    input  logic [5:0]  iram_a,
    input  logic [7:0]  iram_d,
    input  logic        done,
    input  logic [5:0]  res_addr,
    output logic [7:0]  res_q,
    output logic [15:0] checksum,
    output logic [6:0]  wr_count,
    output logic        host_done,
    output logic        err_timeout,
    output logic        err_count,
    output logic        auto_wr
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_GAP,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t state;
    state_t state_nxt;

    // Storage without reset: image, result buffer and queue slots
    logic [7:0] img   [64];
    logic [7:0] res   [64];
    logic [3:0] q_mem [CMD_DEPTH];

    logic [PW-1:0] q_wr_ptr;
    logic [PW-1:0] q_rd_ptr;
    logic [CW-1:0] q_count;
    logic          q_empty;
    logic          q_full;
    logic          push;
    logic          pop;

    logic [WW-1:0] wd_cnt;
    logic          wd_expired;

    logic [3:0]    cmd_nxt;
    logic          cmd_valid_nxt;
    logic          auto_set;
    logic          timeout_set;
    logic          count_chk;

    logic          capture;
    logic [6:0]    wr_count_nxt;

    // ------------------------------------------------------------------
    // Combinational read ports
    // ------------------------------------------------------------------
    assign irom_q = irom_rd ? img[irom_a] : 8'h00;
    assign res_q  = res[res_addr];

    // ------------------------------------------------------------------
    // Queue status and capture qualifiers
    // ------------------------------------------------------------------
    // Depth is a power of two, so the count MSB alone marks "full".
    assign q_full     = q_count[PW];
    assign q_empty    = (q_count == '0);
    assign push       = cmd_we && (state == S_IDLE) && !q_full;
    assign wd_expired = (wd_cnt == WW'(TIMEOUT));

    assign capture      = iram_valid && (state != S_IDLE);
    // Includes the write landing on this edge so the DRAIN->FIN check sees it.
    assign wr_count_nxt = (capture && (wr_count != 7'd127)) ? wr_count + 7'd1 : wr_count;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and registered-output decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        cmd_nxt       = NOOP_CMD;
        cmd_valid_nxt = 1'b0;
        pop           = 1'b0;
        auto_set      = 1'b0;
        timeout_set   = 1'b0;
        count_chk     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wd_expired) begin
                    timeout_set = 1'b1;
                    state_nxt   = S_FIN;
                end else if (!busy && !done) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cmd_valid_nxt = 1'b1;
                if (!q_empty) begin
                    pop     = 1'b1;
                    cmd_nxt = q_mem[q_rd_ptr];
                end else begin
                    // Nothing left to send: finish with a write command.
                    cmd_nxt  = 4'd0;
                    auto_set = 1'b1;
                end
                state_nxt = (cmd_nxt == 4'd0) ? S_DRAIN : S_GAP;
            end
            S_GAP: begin
                state_nxt = S_WAIT;
            end
            S_DRAIN: begin
                if (done) begin
                    count_chk = 1'b1;
                    state_nxt = S_FIN;
                end else if (wd_expired) begin
                    timeout_set = 1'b1;
                    state_nxt   = S_FIN;
                end
            end
            S_FIN: begin
                state_nxt = S_FIN;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered handshake outputs and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd         <= NOOP_CMD;
            cmd_valid   <= 1'b0;
            host_done   <= 1'b0;
            err_timeout <= 1'b0;
            err_count   <= 1'b0;
            auto_wr     <= 1'b0;
        end else begin
            cmd       <= cmd_nxt;
            cmd_valid <= cmd_valid_nxt;
            host_done <= (state_nxt == S_FIN);
            if (timeout_set) begin
                err_timeout <= 1'b1;
            end
            if (count_chk) begin
                err_count <= (wr_count_nxt != 7'd64);
            end
            if (auto_set) begin
                auto_wr <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog: counts idle cycles in WAIT/DRAIN; any issue or write is progress
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (capture || (state == S_ISSUE) || (state == S_IDLE)) begin
            wd_cnt <= '0;
        end else if (((state == S_WAIT) || (state == S_DRAIN)) && !wd_expired) begin
            wd_cnt <= wd_cnt + WW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Command queue pointers; push only in IDLE and pop only in ISSUE,
    // so the two never coincide.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            q_wr_ptr <= '0;
            q_rd_ptr <= '0;
            q_count  <= '0;
        end else begin
            if (push) begin
                q_wr_ptr <= q_wr_ptr + PW'(1);
                q_count  <= q_count + CW'(1);
            end else if (pop) begin
                q_rd_ptr <= q_rd_ptr + PW'(1);
                q_count  <= q_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[q_wr_ptr] <= cmd_din;
        end
    end

    // ------------------------------------------------------------------
    // Source image load and result capture storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (img_we && (state == S_IDLE)) begin
            img[img_addr] <= img_din;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            res[iram_a] <= iram_d;
        end
    end

    // ------------------------------------------------------------------
    // Running checksum and write count
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= 16'd0;
            wr_count <= 7'd0;
        end else begin
            if (capture) begin
                checksum <= checksum + {8'h00, iram_d};
            end
            wr_count <= wr_count_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_host.sv
// Purpose: self-checking bench for lcd_host with a reactive controller model.
// Latency: compares DUT outputs mid-cycle against a queue/arithmetic model every cycle.
// Backpressure: controller model holds busy while "working"; stall case holds it forever.
module tb_lcd_host;

    logic        clk;
    logic        reset;
    logic        img_we;
    logic [5:0]  img_addr;
    logic [7:0]  img_din;
    logic        cmd_we;
    logic [3:0]  cmd_din;
    logic        start;
    logic        irom_rd;
    logic [5:0]  irom_a;
    logic [7:0]  irom_q;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        iram_valid;
    logic [5:0]  iram_a;
    logic [7:0]  iram_d;
    logic        done;
    logic [5:0]  res_addr;
    logic [7:0]  res_q;
    logic [15:0] checksum;
    logic [6:0]  wr_count;
    logic        host_done;
    logic        err_timeout;
    logic        err_count;
    logic        auto_wr;

    lcd_host dut (
        .clk         (clk),
        .reset       (reset),
        .img_we      (img_we),
        .img_addr    (img_addr),
        .img_din     (img_din),
        .cmd_we      (cmd_we),
        .cmd_din     (cmd_din),
        .start       (start),
        .irom_rd     (irom_rd),
        .irom_a      (irom_a),
        .irom_q      (irom_q),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .busy        (busy),
        .iram_valid  (iram_valid),
        .iram_a      (iram_a),
        .iram_d      (iram_d),
        .done        (done),
        .res_addr    (res_addr),
        .res_q       (res_q),
        .checksum    (checksum),
        .wr_count    (wr_count),
        .host_done   (host_done),
        .err_timeout (err_timeout),
        .err_count   (err_count),
        .auto_wr     (auto_wr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    bit armed    = 0;

    // Model state
    bit          m_active = 0;
    logic [15:0] m_sum    = 16'd0;
    logic [6:0]  m_cnt    = 7'd0;
    logic [7:0]  m_res     [64];
    bit          m_res_vld [64];
    logic [3:0]  exp_q [$];
    int          issue_count  = 0;
    bit          m_wr_issued  = 0;
    bit          m_auto       = 0;
    bit          prev_valid   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model update on each active edge, from the inputs the DUT samples.
    initial begin
        for (int i = 0; i < 64; i++) m_res_vld[i] = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_active = 0;
                m_sum    = 16'd0;
                m_cnt    = 7'd0;
                exp_q.delete();
            end else begin
                automatic bit was_active = m_active;
                if (!m_active) begin
                    if (cmd_we && exp_q.size() < 16) exp_q.push_back(cmd_din);
                    if (start) m_active = 1;
                end
                if (was_active && iram_valid) begin
                    m_sum = m_sum + {8'h00, iram_d};
                    if (m_cnt < 7'd127) m_cnt = m_cnt + 7'd1;
                    m_res[iram_a]     = iram_d;
                    m_res_vld[iram_a] = 1;
                end
            end
        end
    end

    // Per-cycle compare, mid-cycle after all input drives have settled.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                issue_count = 0;
                m_wr_issued = 0;
                m_auto      = 0;
                prev_valid  = 0;
            end else if (armed) begin
                if (cmd_valid) begin
                    automatic logic [3:0] exp_op = 4'd0;
                    if (exp_q.size() > 0) begin
                        exp_op = exp_q.pop_front();
                    end else begin
                        m_auto = 1;
                    end
                    chk("issue_op", 32'(cmd), 32'(exp_op));
                    chk("issue_gap", 32'(prev_valid), 32'd0);
                    chk("issue_after_wr", 32'(m_wr_issued), 32'd0);
                    issue_count++;
                    if (exp_op == 4'd0) m_wr_issued = 1;
                end else begin
                    chk("noop_cmd", 32'(cmd), 32'h0000000F);
                end
                prev_valid = cmd_valid;
                chk("checksum", 32'(checksum), 32'(m_sum));
                chk("wr_count", 32'(wr_count), 32'(m_cnt));
                if (m_res_vld[res_addr]) chk("res_q", 32'(res_q), 32'(m_res[res_addr]));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [3:0] op);
        @(negedge clk);
        cmd_we  = 1'b1;
        cmd_din = op;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        cmd_we = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Controller model: busy for 3 cycles per non-write opcode; on opcode 0
    // it reads img[k] through the ROM port and writes img[k]+1 to address k.
    task automatic run_controller(input int nwr);
        int busy_cnt = 0;
        bit writing  = 0;
        int k        = 0;
        bit finished = 0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            iram_valid = 1'b0;
            irom_rd    = 1'b0;
            if (host_done) begin
                finished = 1;
            end else if (cmd_valid) begin
                busy = 1'b1;
                if (cmd == 4'd0) begin
                    writing = 1;
                    k       = 0;
                end else begin
                    busy_cnt = 3;
                end
            end else if (writing) begin
                if (k < nwr) begin
                    irom_rd = 1'b1;
                    irom_a  = 6'(k);
                    #1;
                    iram_valid = 1'b1;
                    iram_a     = 6'(k);
                    iram_d     = irom_q + 8'd1;
                    k++;
                end else begin
                    writing = 0;
                    busy    = 1'b0;
                    done    = 1'b1;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) busy = 1'b0;
            end
        end
        chk("ctrl_finished", 32'(finished), 32'd1);
        done       = 1'b0;
        busy       = 1'b0;
        iram_valid = 1'b0;
        irom_rd    = 1'b0;
    endtask

    task automatic end_checks(input int exp_issues, input logic exp_auto, input logic exp_ecount,
                              input logic [6:0] exp_cnt, input logic [15:0] exp_sum);
        chk("host_done", 32'(host_done), 32'd1);
        chk("err_timeout", 32'(err_timeout), 32'd0);
        chk("err_count", 32'(err_count), 32'(exp_ecount));
        chk("auto_wr", 32'(auto_wr), 32'(exp_auto));
        chk("auto_wr_model", 32'(auto_wr), 32'(m_auto));
        chk("issue_count", 32'(issue_count), 32'(exp_issues));
        chk("final_wr_count", 32'(wr_count), 32'(exp_cnt));
        chk("final_checksum", 32'(checksum), 32'(exp_sum));
    endtask

    initial begin
        reset = 1'b1; img_we = 0; img_addr = 0; img_din = 0; cmd_we = 0; cmd_din = 0;
        start = 0; irom_rd = 0; irom_a = 0; busy = 0; iram_valid = 0; iram_a = 0;
        iram_d = 0; done = 0; res_addr = 0;

        // Reset values
        do_reset();
        #1;
        chk("rst_cmd", 32'(cmd), 32'h0000000F);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        chk("rst_flags", {28'd0, host_done, err_timeout, err_count, auto_wr}, 32'd0);
        armed = 1;

        // Load img[i] = i
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            img_we = 1'b1; img_addr = 6'(i); img_din = 8'(i);
        end
        @(negedge clk);
        img_we = 1'b0;

        // ROM serve
        irom_rd = 1'b1; irom_a = 6'd37;
        #1 chk("irom_37", 32'(irom_q), 32'd37);
        irom_rd = 1'b0;
        #1 chk("irom_off", 32'(irom_q), 32'd0);

        // Full flow {4,7,0}: writes carry i+1, sum 1..64 = 2080
        push(4'd4); push(4'd7); push(4'd0);
        pulse_start();
        run_controller(64);
        end_checks(3, 1'b0, 1'b0, 7'd64, 16'd2080);
        @(negedge clk);
        res_addr = 6'd10;
        #1 chk("res_10", 32'(res_q), 32'd11);
        res_addr = 6'd63;
        #1 chk("res_63", 32'(res_q), 32'd64);

        // Reset mid-state returns flags and counters to zero
        do_reset();
        #1;
        chk("rst2_flags", {28'd0, host_done, err_timeout, err_count, auto_wr}, 32'd0);
        chk("rst2_wr_count", 32'(wr_count), 32'd0);

        // Empty queue: auto write command
        pulse_start();
        run_controller(64);
        end_checks(1, 1'b1, 1'b0, 7'd64, 16'd2080);

        // Queue full: 17 pushes, 17th (9) dropped; 16 issued then the auto write
        do_reset();
        for (int i = 0; i < 17; i++) push(i < 16 ? 4'((i % 11) + 1) : 4'd9);
        pulse_start();
        run_controller(64);
        end_checks(17, 1'b1, 1'b0, 7'd64, 16'd2080);

        // Short write: 60 writes, sum 1..60 = 1830
        do_reset();
        push(4'd0);
        pulse_start();
        run_controller(60);
        end_checks(1, 1'b0, 1'b1, 7'd60, 16'd1830);

        // Stall: busy held, watchdog fires ~4096 cycles after start
        do_reset();
        push(4'd5);
        @(negedge clk);
        busy = 1'b1;
        pulse_start();
        repeat (4000) @(negedge clk);
        chk("stall_not_yet", 32'(host_done), 32'd0);
        repeat (200) @(negedge clk);
        chk("stall_timeout", 32'(err_timeout), 32'd1);
        chk("stall_host_done", 32'(host_done), 32'd1);
        chk("stall_no_issue", 32'(issue_count), 32'd0);
        chk("stall_err_count", 32'(err_count), 32'd0);
        busy = 1'b0;

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
